// File: rtl/mig_seq_eval.sv
// Sequential evaluator for a programmable majority-inverter graph of MAJ3 gates.
// A single MAJ3 unit is time-shared: gate slot g is evaluated in the g-th EVAL cycle.
module mig_seq_eval #(
    parameter int N_IN      = 7,
    parameter int MAX_GATES = 8,
    parameter int SEL_W     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [$clog2(MAX_GATES)-1:0]   cfg_addr,
    input  logic [3*(SEL_W+1)-1:0]         cfg_wdata,
    input  logic                           cfg_len_we,
    input  logic [$clog2(MAX_GATES+1)-1:0] cfg_len,
    input  logic                           cfg_oinv,
    output logic                           busy,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_IN-1:0]                in_x,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_y
);

    localparam int ADDR_W = $clog2(MAX_GATES);
    localparam int LEN_W  = $clog2(MAX_GATES + 1);
    localparam int OP_W   = SEL_W + 1;
    localparam int SLOT_W = 3 * OP_W;
    localparam int SRC_W  = 1 + N_IN + MAX_GATES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [SLOT_W-1:0]      prog_reg [MAX_GATES];
    logic [SLOT_W-1:0]      act_reg  [MAX_GATES];
    logic [LEN_W-1:0]       len_reg;
    logic                   oinv_reg;
    logic [LEN_W-1:0]       act_len_reg;
    logic                   act_oinv_reg;
    logic [N_IN-1:0]        x_reg;
    logic [MAX_GATES-1:0]   res_reg;
    logic [ADDR_W-1:0]      g_reg;
    logic                   out_y_reg;

    logic                   is_idle;
    logic                   accept;
    logic [MAX_GATES-1:0]   slot_we;
    logic [LEN_W-1:0]       len_sat;
    logic [SRC_W-1:0]       src;
    logic [SLOT_W-1:0]      cur_slot;
    logic [2:0]             op_val;
    logic                   maj;
    logic                   last_gate;

    assign is_idle  = (state_reg == IDLE);
    assign accept   = is_idle && in_valid;
    assign len_sat  = (cfg_len > LEN_W'(MAX_GATES)) ? LEN_W'(MAX_GATES) : cfg_len;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_GATES; gi++) begin : g_slot_we
            assign slot_we[gi] = is_idle && cfg_we && (cfg_addr == ADDR_W'(gi));
        end
    endgenerate

    // Operand sources laid out so that the select code indexes them directly:
    // bit 0 is const0, bits 1..N_IN are x0..x6, the rest are gate results g0..g7.
    assign src      = {res_reg, x_reg, 1'b0};
    assign cur_slot = act_reg[g_reg];

    generate
        for (gi = 0; gi < 3; gi++) begin : g_operand
            assign op_val[gi] = src[cur_slot[gi*OP_W +: SEL_W]] ^ cur_slot[gi*OP_W + SEL_W];
        end
    endgenerate

    assign maj       = (op_val[0] & op_val[1]) | (op_val[0] & op_val[2]) | (op_val[1] & op_val[2]);
    assign last_gate = (LEN_W'(g_reg) == (act_len_reg - LEN_W'(1)));

    // The shadow program takes config writes; the active copy is snapshotted at
    // accept so a same-cycle write only affects the following vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_GATES; i++) begin
                prog_reg[i] <= '0;
                act_reg[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_GATES; i++) begin
                if (slot_we[i]) begin
                    prog_reg[i] <= cfg_wdata;
                end
                if (accept) begin
                    act_reg[i] <= prog_reg[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            oinv_reg     <= 1'b0;
            act_len_reg  <= '0;
            act_oinv_reg <= 1'b0;
            x_reg        <= '0;
            res_reg      <= '0;
            g_reg        <= '0;
            out_y_reg    <= 1'b0;
        end else begin
            if (is_idle && cfg_len_we) begin
                len_reg  <= len_sat;
                oinv_reg <= cfg_oinv;
            end
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        x_reg        <= in_x;
                        res_reg      <= '0;
                        g_reg        <= '0;
                        act_len_reg  <= len_reg;
                        act_oinv_reg <= oinv_reg;
                        if (len_reg == '0) begin
                            out_y_reg <= oinv_reg;
                            state_reg <= HOLD;
                        end else begin
                            state_reg <= EVAL;
                        end
                    end
                end
                EVAL: begin
                    res_reg[g_reg] <= maj;
                    if (last_gate) begin
                        out_y_reg <= maj ^ act_oinv_reg;
                        state_reg <= HOLD;
                    end else begin
                        g_reg <= g_reg + ADDR_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // in_ready is masked by rst so it reads low for the whole reset pulse.
    assign in_ready  = is_idle && !rst;
    assign busy      = !is_idle;
    assign out_valid = (state_reg == HOLD);
    assign out_y     = out_y_reg;

endmodule

// File: tb/tb_mig_seq_eval.sv
// Randomized self-checking bench for mig_seq_eval against a gate-by-gate reference model.
module tb_mig_seq_eval;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [14:0] cfg_wdata;
    logic        cfg_len_we;
    logic [3:0]  cfg_len;
    logic        cfg_oinv;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_x;
    logic        out_valid;
    logic        out_ready;
    logic        out_y;

    int checks = 0;
    int errors = 0;

    logic [14:0] model_prog [8];
    int          model_len;
    logic        model_oinv;

    mig_seq_eval dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_len_we (cfg_len_we),
        .cfg_len    (cfg_len),
        .cfg_oinv   (cfg_oinv),
        .busy       (busy),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Gate-by-gate evaluation with majority by counting ones.
    function automatic logic model_eval(input logic [6:0] x);
        logic [7:0] r;
        int         ones;
        int         sel;
        logic       v;
        r = '0;
        if (model_len == 0) return model_oinv;
        for (int g = 0; g < model_len; g++) begin
            ones = 0;
            for (int k = 0; k < 3; k++) begin
                sel = int'(model_prog[g][k*5 +: 4]);
                if (sel == 0)      v = 1'b0;
                else if (sel <= 7) v = x[sel-1];
                else               v = r[sel-8];
                v = v ^ model_prog[g][k*5+4];
                ones += int'(v);
            end
            r[g] = (ones >= 2);
        end
        return r[model_len-1] ^ model_oinv;
    endfunction

    function automatic logic [14:0] slot(input int sa, input bit ia, input int sb, input bit ib,
                                         input int sc, input bit ic);
        return {ic, 4'(sc), ib, 4'(sb), ia, 4'(sa)};
    endfunction

    task automatic write_slot(input logic [2:0] a, input logic [14:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        model_prog[a] = d;
    endtask

    task automatic write_len(input logic [3:0] l, input logic o);
        cfg_len_we = 1'b1; cfg_len = l; cfg_oinv = o;
        @(posedge clk); #1;
        cfg_len_we = 1'b0;
        model_len  = (l > 4'd8) ? 8 : int'(l);
        model_oinv = o;
    endtask

    // One transaction: accept, wait for the result, check latency and value, retire.
    task automatic run_vec(input logic [6:0] x, input string tag, input bit cfg_at_accept,
                           input bit cfg_in_eval, input logic [2:0] a, input logic [14:0] d);
        logic exp;
        int   cyc;
        int   len_used;
        exp      = model_eval(x);
        len_used = model_len;
        check_value({tag, "_in_ready"}, int'(in_ready), 1);
        in_x = x; in_valid = 1'b1;
        if (cfg_at_accept) begin
            cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        in_x     = 7'($urandom);
        if (cfg_at_accept) model_prog[a] = d;
        cyc = 0;
        while (!out_valid && cyc < 30) begin
            if (cfg_in_eval && cyc == 0) begin
                cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
            cyc++;
        end
        if (len_used == 0) check_value({tag, "_lat"}, int'(cyc <= 1), 1);
        else               check_value({tag, "_lat"}, cyc, len_used);
        check_value({tag, "_y"}, int'(out_y), int'(exp));
        $display("vec %s x=%b len=%0d y=%b exp=%b lat=%0d", tag, x, len_used, out_y, exp, cyc);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_value({tag, "_retire"}, int'(out_valid), 0);
    endtask

    task automatic random_program(input int len);
        for (int s = 0; s < 8; s++) write_slot(3'(s), 15'($urandom));
        write_len(4'(len), 1'($urandom));
    endtask

    initial begin
        logic [6:0]  xa;
        logic [6:0]  xb;
        logic        ea;
        logic        eb;
        logic [14:0] dnew;
        int          cyc;
        bit          seen;

        rst = 1'b1; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; cfg_len_we = 0;
        cfg_len = 0; cfg_oinv = 0; in_valid = 0; in_x = 0; out_ready = 0;
        for (int s = 0; s < 8; s++) model_prog[s] = '0;
        model_len = 0; model_oinv = 0;

        repeat (2) @(posedge clk);
        #1;
        check_value("rst_in_ready", int'(in_ready), 0);
        check_value("rst_busy", int'(busy), 0);
        check_value("rst_out_valid", int'(out_valid), 0);
        check_value("rst_out_y", int'(out_y), 0);
        rst = 1'b0;
        #1;
        check_value("idle_in_ready", int'(in_ready), 1);

        // MAJ(x0,x1,x2)
        write_slot(3'd0, slot(1, 0, 2, 0, 3, 0));
        write_len(4'd1, 1'b0);
        run_vec(7'b0000011, "t1_a", 0, 0, 0, 0);
        run_vec(7'b0000100, "t1_b", 0, 0, 0, 0);

        // g0=MAJ(x2,x3,x6), g1=MAJ(x0,g0,x1), full sweep
        write_slot(3'd0, slot(3, 0, 4, 0, 7, 0));
        write_slot(3'd1, slot(1, 0, 8, 0, 2, 0));
        write_len(4'd2, 1'b0);
        for (int v = 0; v < 128; v++) run_vec(7'(v), "t2", 0, 0, 0, 0);

        // Empty program with inverted output, then a buffer built from MAJ(~0,x0,0)
        write_len(4'd0, 1'b1);
        for (int v = 0; v < 4; v++) run_vec(7'($urandom), "t3_len0", 0, 0, 0, 0);
        write_slot(3'd0, slot(0, 1, 1, 0, 0, 0));
        write_len(4'd1, 1'b0);
        for (int v = 0; v < 4; v++) run_vec(7'($urandom), "t3_buf", 0, 0, 0, 0);

        // Back-pressure: stall in HOLD with a new vector already waiting
        write_slot(3'd0, slot(3, 0, 4, 0, 7, 0));
        write_slot(3'd1, slot(1, 0, 8, 0, 2, 0));
        write_len(4'd2, 1'b0);
        xa = 7'($urandom); xb = ~xa;
        ea = model_eval(xa); eb = model_eval(xb);
        in_x = xa; in_valid = 1'b1;
        @(posedge clk); #1;
        in_x = xb;
        cyc = 0;
        while (!out_valid && cyc < 30) begin @(posedge clk); #1; cyc++; end
        check_value("t4_lat", cyc, 2);
        for (int i = 0; i < 5; i++) begin
            check_value("t4_hold_valid", int'(out_valid), 1);
            check_value("t4_hold_y", int'(out_y), int'(ea));
            check_value("t4_hold_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check_value("t4_pre_release", int'(out_valid), 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_value("t4_idle_in_ready", int'(in_ready), 1);
        check_value("t4_idle_busy", int'(busy), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_value("t4_second_busy", int'(busy), 1);
        cyc = 0;
        while (!out_valid && cyc < 30) begin @(posedge clk); #1; cyc++; end
        check_value("t4_second_lat", cyc, 2);
        check_value("t4_second_y", int'(out_y), int'(eb));
        $display("vec t4 x=%b y=%b exp=%b", xb, out_y, eb);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Config write while busy is dropped; at accept it applies to the next vector
        random_program(4);
        dnew = ~model_prog[0];
        xa   = 7'($urandom);
        run_vec(xa, "t5_busy_wr", 0, 1, 3'd0, dnew);
        run_vec(xa, "t5_busy_wr2", 0, 0, 0, 0);
        run_vec(xa, "t5_accept_wr", 1, 0, 3'd0, dnew);
        run_vec(xa, "t5_next", 0, 0, 0, 0);

        // Random programs, including length saturation
        for (int p = 0; p < 20; p++) begin
            random_program($urandom_range(15, 0));
            for (int v = 0; v < 5; v++) run_vec(7'($urandom), "rand", 0, 0, 0, 0);
        end

        // Reset in the middle of a long evaluation
        random_program(8);
        in_x = 7'($urandom); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_value("t6_rst_busy", int'(busy), 0);
        check_value("t6_rst_out_valid", int'(out_valid), 0);
        check_value("t6_rst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int s = 0; s < 8; s++) model_prog[s] = '0;
        model_len = 0; model_oinv = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1;
            @(posedge clk); #1;
        end
        check_value("t6_no_result", int'(seen), 0);
        check_value("t6_in_ready", int'(in_ready), 1);
        run_vec(7'($urandom), "t6_len0", 0, 0, 0, 0);
        write_len(4'd8, 1'b1);
        run_vec(7'($urandom), "t6_zero_prog", 0, 0, 0, 0);
        write_len(4'd8, 1'b0);
        run_vec(7'($urandom), "t6_zero_prog_b", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
